// File: rtl/axi_ost_slot_ctrl.sv
// Outstanding-slot controller: allocates free slots to requests, records completions, and
// returns completed head-of-queue slots round-robin, one grant per two cycles at most.
module axi_ost_slot_ctrl #(
    parameter int OST_DEPTH = 16,
    parameter int ID_WIDTH  = 4,
    localparam int PTR_W    = $clog2(OST_DEPTH + 1),
    localparam int IDX_W    = (OST_DEPTH > 1) ? $clog2(OST_DEPTH) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 s_req_valid,
    input  logic [ID_WIDTH-1:0]  s_req_id,
    output logic                 s_req_ready,
    output logic [PTR_W-1:0]     alloc_ptr,
    input  logic                 cpl_valid,
    input  logic [PTR_W-1:0]     cpl_ptr,
    input  logic [OST_DEPTH-1:0] head_bits,
    output logic                 rd_valid,
    output logic [PTR_W-1:0]     rd_ptr,
    output logic [ID_WIDTH-1:0]  rd_id,
    input  logic                 rd_ready,
    output logic [PTR_W-1:0]     ost_cnt,
    output logic                 cpl_err
);

    typedef enum logic {S_IDLE, S_ISSUE} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [OST_DEPTH-1:0]  r_valid;
    logic [OST_DEPTH-1:0]  r_done;
    logic [ID_WIDTH-1:0]   r_id [OST_DEPTH];
    logic [IDX_W-1:0]      r_rr;
    logic                  r_rd_valid;
    logic [IDX_W-1:0]      r_rd_idx;
    logic [ID_WIDTH-1:0]   r_rd_id;
    logic [PTR_W-1:0]      r_cnt;
    logic                  r_err;

    logic [IDX_W-1:0]      w_alloc_idx;
    logic                  w_alloc;
    logic [IDX_W-1:0]      w_cpl_idx;
    logic                  w_cpl_ok;
    logic [OST_DEPTH-1:0]  w_elig;
    logic                  w_pick_vld;
    logic [IDX_W-1:0]      w_pick;
    logic                  w_load;
    logic                  w_free;

    always_comb begin
        w_alloc_idx = '0;
        for (int i = OST_DEPTH - 1; i >= 0; i--) begin
            if (!r_valid[i]) w_alloc_idx = IDX_W'(i);
        end
    end

    assign s_req_ready = ~&r_valid;
    assign alloc_ptr   = PTR_W'(w_alloc_idx);
    assign w_alloc     = s_req_valid && s_req_ready;

    // A completion is legal only for an occupied, not-yet-done slot as seen at cycle start.
    assign w_cpl_idx = cpl_ptr[IDX_W-1:0];
    assign w_cpl_ok  = cpl_valid && (cpl_ptr < PTR_W'(OST_DEPTH)) &&
                       r_valid[w_cpl_idx] && !r_done[w_cpl_idx];

    assign w_elig = r_valid & r_done & head_bits;

    // Scan downward from the farthest candidate so the nearest one after r_rr wins.
    always_comb begin
        logic [IDX_W-1:0] w_idx;
        w_idx      = '0;
        w_pick_vld = 1'b0;
        w_pick     = '0;
        for (int i = OST_DEPTH; i >= 1; i--) begin
            w_idx = IDX_W'((int'(r_rr) + i) % OST_DEPTH);
            if (w_elig[w_idx]) begin
                w_pick_vld = 1'b1;
                w_pick     = w_idx;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_free      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_pick_vld) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (rd_ready) begin
                    w_free      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Alloc, completion and free never hit the same slot in one cycle, so their writes are disjoint.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_done  <= '0;
            for (int i = 0; i < OST_DEPTH; i++) r_id[i] <= '0;
        end else begin
            if (w_alloc) begin
                r_valid[w_alloc_idx] <= 1'b1;
                r_done[w_alloc_idx]  <= 1'b0;
                r_id[w_alloc_idx]    <= s_req_id;
            end
            if (w_cpl_ok) r_done[w_cpl_idx] <= 1'b1;
            if (w_free) begin
                r_valid[r_rd_idx] <= 1'b0;
                r_done[r_rd_idx]  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr       <= IDX_W'(OST_DEPTH - 1);
            r_rd_valid <= 1'b0;
            r_rd_idx   <= '0;
            r_rd_id    <= '0;
            r_cnt      <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_load) begin
                r_rd_valid <= 1'b1;
                r_rd_idx   <= w_pick;
                r_rd_id    <= r_id[w_pick];
            end else if (w_free) begin
                r_rd_valid <= 1'b0;
                r_rr       <= r_rd_idx;
            end
            case ({w_alloc, w_free})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
            if (cpl_valid && !w_cpl_ok) r_err <= 1'b1;
        end
    end

    assign rd_valid = r_rd_valid;
    assign rd_ptr   = PTR_W'(r_rd_idx);
    assign rd_id    = r_rd_id;
    assign ost_cnt  = r_cnt;
    assign cpl_err  = r_err;

endmodule
